// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO register block: register map and default pin count.
package gpio_pkg;

    localparam int GPIO_W_DEFAULT = 16;

    localparam logic [2:0] ADDR_PINSTATE = 3'b000;
    localparam logic [2:0] ADDR_DATAREG  = 3'b001;
    localparam logic [2:0] ADDR_TRISTATE = 3'b010;
    localparam logic [2:0] ADDR_INTMASK  = 3'b110;

    // Expands the two low byte enables into a 16-bit bit mask; upper lanes carry no register bits.
    function automatic logic [15:0] lane_mask(input logic [3:0] wben);
        lane_mask = {{8{wben[1]}}, {8{wben[0]}}};
    endfunction

endpackage

// File: rtl/gpio_sync2.sv
// Purpose: W-wide two-flop synchronizer for raw pad levels into the clk domain.
// Latency: 2 clk edges from a stable input to q.
// Backpressure: none; samples every edge.
module gpio_sync2 #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            q      <= '0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/register.sv
// Purpose: GPIO control/status register file on a word-addressed bus (data, tristate, irq mask, pin state).
// Latency: writes visible on rf_* the cycle after the write edge; rdata valid 1 cycle after a read edge.
// Backpressure: none; every bus cycle completes in one edge, r_wn=1 blocks all writes.
module register
    import gpio_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int GPIO_W = GPIO_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:2]        addr,
    input  logic [3:0]        wben,
    input  logic              r_wn,
    input  logic [DATA_W-1:0] wdata,
    input  logic [GPIO_W-1:0] ro_gpio_pinstate,
    output logic [DATA_W-1:0] rdata,
    output logic [GPIO_W-1:0] rf_gpio_datareg,
    output logic [GPIO_W-1:0] rf_gpio_tristate,
    output logic [GPIO_W-1:0] rf_gpio_interrupt_mask
);

    logic [GPIO_W-1:0] pin_sync;
    logic [15:0]       wr_mask_full;
    logic [GPIO_W-1:0] wr_mask;
    logic [GPIO_W-1:0] wr_bits;
    logic [DATA_W-1:0] rd_word;

    // Only lanes 0-1 carry register bits; the rest of the bus is intentionally ignored.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{wben[3:2], wdata[DATA_W-1:GPIO_W], wr_mask_full};

    gpio_sync2 #(
        .W (GPIO_W)
    ) u_pin_sync (
        .clk   (clk),
        .rst_n (reset),
        .d     (ro_gpio_pinstate),
        .q     (pin_sync)
    );

    assign wr_mask_full = lane_mask(wben);
    assign wr_mask      = wr_mask_full[GPIO_W-1:0];
    assign wr_bits      = wdata[GPIO_W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_gpio_datareg        <= '0;
            rf_gpio_tristate       <= '0;
            rf_gpio_interrupt_mask <= '0;
        end else if (!r_wn) begin
            case (addr)
                ADDR_DATAREG:
                    rf_gpio_datareg <= (rf_gpio_datareg & ~wr_mask) | (wr_bits & wr_mask);
                ADDR_TRISTATE:
                    rf_gpio_tristate <= (rf_gpio_tristate & ~wr_mask) | (wr_bits & wr_mask);
                ADDR_INTMASK:
                    rf_gpio_interrupt_mask <= (rf_gpio_interrupt_mask & ~wr_mask) | (wr_bits & wr_mask);
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_word = '0;
        case (addr)
            ADDR_PINSTATE: rd_word[GPIO_W-1:0] = pin_sync;
            ADDR_DATAREG:  rd_word[GPIO_W-1:0] = rf_gpio_datareg;
            ADDR_TRISTATE: rd_word[GPIO_W-1:0] = rf_gpio_tristate;
            ADDR_INTMASK:  rd_word[GPIO_W-1:0] = rf_gpio_interrupt_mask;
            default:       rd_word = '0;
        endcase
    end

    // rdata only moves on read cycles so a write never disturbs the last read result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (r_wn) begin
            rdata <= rd_word;
        end
    end

endmodule

// File: tb/tb_register.sv
// Directed self-checking bench for the GPIO register file.
module tb_register;

    logic        clk;
    logic        reset;
    logic [4:2]  addr;
    logic [3:0]  wben;
    logic        r_wn;
    logic [31:0] wdata;
    logic [15:0] ro_gpio_pinstate;
    logic [31:0] rdata;
    logic [15:0] rf_gpio_datareg;
    logic [15:0] rf_gpio_tristate;
    logic [15:0] rf_gpio_interrupt_mask;

    int tests_run;
    int tests_failed;

    register #(
        .DATA_W (32),
        .GPIO_W (16)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .addr                   (addr),
        .wben                   (wben),
        .r_wn                   (r_wn),
        .wdata                  (wdata),
        .ro_gpio_pinstate       (ro_gpio_pinstate),
        .rdata                  (rdata),
        .rf_gpio_datareg        (rf_gpio_datareg),
        .rf_gpio_tristate       (rf_gpio_tristate),
        .rf_gpio_interrupt_mask (rf_gpio_interrupt_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs are driven and outputs sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        r_wn  = 1'b1;
        addr  = 3'b000;
        wben  = 4'b0000;
        wdata = 32'h0;
        ro_gpio_pinstate = 16'h0;
        #23;
        reset = 1'b1;
        tick();
        tests_run++;
        if (rf_gpio_datareg !== 16'h0 || rf_gpio_tristate !== 16'h0 || rf_gpio_interrupt_mask !== 16'h0) begin
            tests_failed++;
            $display("FAIL reset_rf: data=%h tri=%h mask=%h expected all 0000",
                     rf_gpio_datareg, rf_gpio_tristate, rf_gpio_interrupt_mask);
        end
        for (int a = 0; a < 8; a++) begin
            addr = a[2:0];
            tick();
            tests_run++;
            if (rdata !== 32'h0) begin
                tests_failed++;
                $display("FAIL reset_read addr=%0d: rdata=%h expected 00000000", a, rdata);
            end
        end
    endtask

    task automatic test_read_blocks_write();
        r_wn  = 1'b1;
        addr  = 3'b110;
        wben  = 4'b1111;
        wdata = 32'h0000_8001;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (rf_gpio_interrupt_mask !== 16'h0 || rdata !== 32'h0) begin
                tests_failed++;
                $display("FAIL read_blocks_write cyc%0d: mask=%h rdata=%h expected 0000/00000000",
                         i, rf_gpio_interrupt_mask, rdata);
            end
        end
    endtask

    task automatic test_byte_lanes();
        logic [3:0]  wben_seq [4];
        logic [15:0] mask_exp [4];
        wben_seq = '{4'b0000, 4'b0001, 4'b0010, 4'b1011};
        mask_exp = '{16'h0000, 16'h0049, 16'h9249, 16'h9249};
        addr  = 3'b110;
        r_wn  = 1'b0;
        wdata = 32'hFFFF_9249;
        for (int i = 0; i < 4; i++) begin
            wben = wben_seq[i];
            tick();
            tests_run++;
            if (rf_gpio_interrupt_mask !== mask_exp[i] || rdata !== 32'h0) begin
                tests_failed++;
                $display("FAIL byte_lane wben=%b: mask=%h rdata=%h expected %h/00000000",
                         wben_seq[i], rf_gpio_interrupt_mask, rdata, mask_exp[i]);
            end
        end
    endtask

    task automatic test_read_and_async_reset();
        addr = 3'b110;
        r_wn = 1'b1;
        wben = 4'b0000;
        tick();
        tests_run++;
        if (rdata !== 32'h0000_9249) begin
            tests_failed++;
            $display("FAIL read_intmask: rdata=%h expected 00009249", rdata);
        end
        reset = 1'b0;
        #2;
        tests_run++;
        if (rdata !== 32'h0 || rf_gpio_interrupt_mask !== 16'h0) begin
            tests_failed++;
            $display("FAIL async_reset: rdata=%h mask=%h expected 00000000/0000",
                     rdata, rf_gpio_interrupt_mask);
        end
        #2;
        reset = 1'b1;
    endtask

    task automatic test_data_tristate();
        r_wn  = 1'b0;
        wben  = 4'b0011;
        addr  = 3'b001;
        wdata = 32'h0000_A5A5;
        tick();
        tests_run++;
        if (rf_gpio_datareg !== 16'hA5A5 || rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL write_datareg: data=%h rdata=%h expected A5A5/00000000",
                     rf_gpio_datareg, rdata);
        end
        addr  = 3'b010;
        wdata = 32'h0000_0F0F;
        tick();
        tests_run++;
        if (rf_gpio_tristate !== 16'h0F0F || rf_gpio_datareg !== 16'hA5A5) begin
            tests_failed++;
            $display("FAIL write_tristate: tri=%h data=%h expected 0F0F/A5A5",
                     rf_gpio_tristate, rf_gpio_datareg);
        end
        addr  = 3'b111;
        wdata = 32'hFFFF_FFFF;
        wben  = 4'b1111;
        tick();
        tests_run++;
        if (rf_gpio_datareg !== 16'hA5A5 || rf_gpio_tristate !== 16'h0F0F || rf_gpio_interrupt_mask !== 16'h0) begin
            tests_failed++;
            $display("FAIL reserved_write: data=%h tri=%h mask=%h expected A5A5/0F0F/0000",
                     rf_gpio_datareg, rf_gpio_tristate, rf_gpio_interrupt_mask);
        end
        r_wn = 1'b1;
        wben = 4'b0000;
        addr = 3'b001;
        tick();
        tests_run++;
        if (rdata !== 32'h0000_A5A5) begin
            tests_failed++;
            $display("FAIL read_datareg: rdata=%h expected 0000A5A5", rdata);
        end
        addr = 3'b010;
        tick();
        tests_run++;
        if (rdata !== 32'h0000_0F0F) begin
            tests_failed++;
            $display("FAIL read_tristate: rdata=%h expected 00000F0F", rdata);
        end
        addr = 3'b111;
        tick();
        tests_run++;
        if (rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL read_reserved: rdata=%h expected 00000000", rdata);
        end
    endtask

    task automatic test_pinstate();
        logic [31:0] exp_seq [3];
        exp_seq = '{32'h0, 32'h0, 32'h0000_1234};
        addr = 3'b000;
        r_wn = 1'b1;
        tick();
        ro_gpio_pinstate = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (rdata !== exp_seq[i]) begin
                tests_failed++;
                $display("FAIL pinstate edge%0d: rdata=%h expected %h", i + 1, rdata, exp_seq[i]);
            end
        end
        r_wn  = 1'b0;
        wben  = 4'b0011;
        wdata = 32'h0000_FFFF;
        tick();
        tests_run++;
        if (rf_gpio_datareg !== 16'hA5A5 || rf_gpio_tristate !== 16'h0F0F ||
            rf_gpio_interrupt_mask !== 16'h0 || rdata !== 32'h0000_1234) begin
            tests_failed++;
            $display("FAIL pinstate_write: data=%h tri=%h mask=%h rdata=%h expected A5A5/0F0F/0000/00001234",
                     rf_gpio_datareg, rf_gpio_tristate, rf_gpio_interrupt_mask, rdata);
        end
        r_wn = 1'b1;
        wben = 4'b0000;
        tick();
        tests_run++;
        if (rdata !== 32'h0000_1234) begin
            tests_failed++;
            $display("FAIL pinstate_reread: rdata=%h expected 00001234", rdata);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_read_blocks_write();
        test_byte_lanes();
        test_read_and_async_reset();
        test_data_tristate();
        test_pinstate();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/register.md
Name: register

Overview:
- Memory-mapped GPIO control/status register file on a 32-bit word-addressed bus.
- Holds the 16-bit GPIO data, tristate and interrupt-mask registers, each driven continuously to the GPIO pin logic.
- Exposes the pin state as a read-only register.
- Sits between the bus slave interface and the GPIO pad/interrupt logic.

Parameters:
- DATA_W, 32, bus data width (wdata/rdata)
- GPIO_W, 16, GPIO pin count and register field width (must be <= 16, i.e. fits bytes 0-1)

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-low reset
- addr  input  3 [4:2]  word address within block
- wben  input  4  byte write enables; bit n covers wdata[8n+7:8n]
- r_wn  input  1  1 = read cycle, 0 = write cycle
- wdata  input  DATA_W  write data
- ro_gpio_pinstate  input  GPIO_W  raw pin levels (asynchronous to clk)
- rdata  output  DATA_W  registered read data
- rf_gpio_datareg  output  GPIO_W  GPIO output data register
- rf_gpio_tristate  output  GPIO_W  tristate register (1 = pin driven)
- rf_gpio_interrupt_mask  output  GPIO_W  interrupt mask register (1 = enabled)

Behaviour:
- Register map (addr[4:2]):
  - 3'b000 PINSTATE, RO
  - 3'b001 DATAREG, RW
  - 3'b010 TRISTATE, RW
  - 3'b110 INT_MASK, RW
  - all other addresses reserved: read 0, writes ignored.
- Reset (reset low, asynchronous): DATAREG, TRISTATE, INT_MASK, rdata and the synchronizer flops all clear to 0.
- Write:
  - Occurs on a rising clk edge when r_wn=0.
  - Byte lane n of the addressed RW register updates from wdata when wben[n]=1; other lanes hold.
  - Lanes 0-1 map to register bits [15:0]; wben[3:2] and wdata[31:16] are ignored.
  - wben=0 with r_wn=0 changes nothing.
- r_wn=1 blocks all writes regardless of wben.
- Register outputs reflect a written value the cycle after the write edge.
- Read:
  - On each rising edge with r_wn=1, rdata loads the addressed register, zero-extended to DATA_W.
  - Read latency is 1 cycle.
  - While r_wn=0, rdata holds its last value and is not updated by writes.
- PINSTATE:
  - ro_gpio_pinstate passes through a 2-flop synchronizer; PINSTATE reads the second stage.
  - Pin change to rdata takes 3 edges.
- No reset mid-transaction recovery is needed: asserting reset at any point clears all state immediately; the first edge after deassertion behaves normally.
- Simultaneous address change and r_wn toggle: sample addr/r_wn/wben/wdata at the same edge; no pipelining of bus inputs.

Decomposition:
- Shared package gpio_pkg:
  - address constants ADDR_PINSTATE=3'b000, ADDR_DATAREG=3'b001, ADDR_TRISTATE=3'b010, ADDR_INTMASK=3'b110
  - GPIO_W default.
- One natural sub-module: gpio_sync2, a GPIO_W-wide 2-flop synchronizer with async active-low reset.
- Byte-lane write logic stays inline.

Test Plan:
- Reset low then high; read each address with r_wn=1 -> rdata=0, all rf_* outputs 0.
- r_wn=1, addr=3'b110, wben=4'b1111, wdata=0x00008001 for several cycles -> INT_MASK stays 0, rdata stays 0.
- addr=3'b110, r_wn=0, wdata=0xFFFF9249, wben sequence:
  - 4'b0000 -> mask 0x0000
  - 4'b0001 -> mask 0x0049
  - 4'b0010 -> mask 0x9249
  - 4'b1011 -> mask 0x9249
  - rdata unchanged throughout.
- Set r_wn=1 at addr=3'b110 -> rdata=0x00009249 one cycle later. Pulse reset low -> rdata and rf_gpio_interrupt_mask return to 0 immediately.
- Write 0xA5A5 to DATAREG (3'b001) and 0x0F0F to TRISTATE (3'b010) with wben=4'b0011 -> rf_gpio_datareg=0xA5A5, rf_gpio_tristate=0x0F0F. Read both back; write to reserved 3'b111 -> reads 0.
- ro_gpio_pinstate=0x1234, addr=3'b000, r_wn=1 -> rdata=0x00001234 on the third edge after the change. Write to addr 3'b000 -> no effect.
